c6_lane_collector: RTL and testbench

//  Sequential consumer of the C6 byte transform in the hash datapath.

---
 rtl/c6_lane_collector_if.sv | 32 +++
 rtl/c6_lane_collector.sv | 114 +++++++++++
 tb/tb_c6_lane_collector.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/c6_lane_collector_if.sv
`default_nettype none
// ============================================================================
//  Module      : c6_lane_collector_if
//  Description : Upstream word / downstream packed-result handshake bundle
//                for the C6 lane collector, plus its status outputs.
//  Revision    : 1.0  initial release
// ============================================================================
interface c6_lane_collector_if #(
    parameter int N_LANES    = 8,
    parameter int LANE_W_IN  = 8,
    parameter int LANE_W_OUT = 6
);
    logic                            in_valid;
    logic                            in_ready;
    logic [N_LANES*LANE_W_IN-1:0]    in_c;
    logic                            out_valid;
    logic                            out_ready;
    logic [N_LANES*LANE_W_OUT-1:0]   out_c6;
    logic                            busy;
    logic [2:0]                      lane_idx;

    modport master (
        output in_valid, in_c, out_ready,
        input  in_ready, out_valid, out_c6, busy, lane_idx
    );

    modport slave (
        input  in_valid, in_c, out_ready,
        output in_ready, out_valid, out_c6, busy, lane_idx
    );
endinterface
`default_nettype wire

// File: rtl/c6_lane_collector.sv
`default_nettype none
// ============================================================================
//  Module      : c6_lane_collector
//  Description : Walks the eight byte lanes of a captured C word one per
//                cycle, applies the C6 bit transform and packs the 6-bit
//                results into a 48-bit word handed off over valid/ready.
//  Revision    : 1.0  initial release
// ============================================================================
module c6_lane_collector #(
    parameter int N_LANES    = 8,
    parameter int LANE_W_IN  = 8,
    parameter int LANE_W_OUT = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    c6_lane_collector_if.slave    bus
);
    localparam int         c_IDX_W   = 3;
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    logic [1:0]                     r_state;
    logic [1:0]                     w_state_nxt;
    logic                           r_in_ready;
    logic                           r_out_valid;
    logic                           r_busy;
    logic                           w_in_ready_nxt;
    logic                           w_out_valid_nxt;
    logic                           w_busy_nxt;
    logic [N_LANES*LANE_W_IN-1:0]   r_c;
    logic [N_LANES*LANE_W_OUT-1:0]  r_out_c6;
    logic [c_IDX_W-1:0]             r_lane_idx;
    logic                           w_last_lane;
    logic [LANE_W_OUT-1:0]          w_lane_c6 [N_LANES];

    assign w_last_lane = (r_lane_idx == c_IDX_W'(N_LANES - 1));

    // Every lane's transform is available in parallel; the walk only selects
    // which slice of the packed result gets written on a given edge.
    generate
        for (genvar g = 0; g < N_LANES; g++) begin : g_lane
            logic [LANE_W_IN-1:0] w_b;
            assign w_b          = r_c[g*LANE_W_IN +: LANE_W_IN];
            assign w_lane_c6[g] = {w_b[7] ^ w_b[1], w_b[3], w_b[2],
                                   w_b[5] ^ w_b[0], w_b[4], w_b[6]};
        end
    endgenerate

    // State register; handshake/status flags are registered from the next state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= c_ST_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= w_in_ready_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (bus.in_valid)  w_state_nxt = c_ST_RUN;
            c_ST_RUN:  if (w_last_lane)   w_state_nxt = c_ST_DONE;
            c_ST_DONE: if (bus.out_ready) w_state_nxt = c_ST_IDLE;
            default:                      w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_comb begin
        w_in_ready_nxt  = (w_state_nxt == c_ST_IDLE);
        w_busy_nxt      = (w_state_nxt == c_ST_RUN);
        w_out_valid_nxt = (w_state_nxt == c_ST_DONE);
    end

    // Capture and lane-walk datapath
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_c        <= '0;
            r_out_c6   <= '0;
            r_lane_idx <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_c        <= bus.in_c;
                        r_out_c6   <= '0;
                        r_lane_idx <= '0;
                    end
                end
                c_ST_RUN: begin
                    for (int k = 0; k < N_LANES; k++) begin
                        if (r_lane_idx == c_IDX_W'(k))
                            r_out_c6[k*LANE_W_OUT +: LANE_W_OUT] <= w_lane_c6[k];
                    end
                    r_lane_idx <= r_lane_idx + c_IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = r_busy;
    assign bus.out_c6    = r_out_c6;
    assign bus.lane_idx  = r_lane_idx;
endmodule
`default_nettype wire

// File: tb/tb_c6_lane_collector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_c6_lane_collector
//  Description : Directed self-checking bench for c6_lane_collector.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_c6_lane_collector;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    c6_lane_collector_if bus ();

    c6_lane_collector u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic accept_word(input logic [63:0] c);
        bus.in_c     = c;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    // Returns edges waited until out_valid, or -1 if the budget ran out.
    task automatic wait_valid(output int n);
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (bus.out_valid !== 1'b1) n = -1;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_c      = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.out_c6 !== 48'h0) begin failures++; $display("FAIL reset_out_c6 got=%h exp=0", bus.out_c6); end
        checks++; if (bus.lane_idx !== 3'd0) begin failures++; $display("FAIL reset_lane_idx got=%0d exp=0", bus.lane_idx); end
    endtask

    task automatic test_zero_word();
        int n;
        accept_word(64'h0);
        checks++; if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin failures++; $display("FAIL zero_run_flags got busy=%b in_ready=%b exp busy=1 in_ready=0", bus.busy, bus.in_ready); end
        wait_valid(n);
        checks++; if (n !== 8) begin failures++; $display("FAIL zero_latency got=%0d exp=8", n); end
        checks++; if (bus.out_c6 !== 48'h000000000000) begin failures++; $display("FAIL zero_out_c6 got=%h exp=000000000000", bus.out_c6); end
        checks++; if (bus.in_ready !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("FAIL zero_done_flags got in_ready=%b busy=%b exp 0 0", bus.in_ready, bus.busy); end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin failures++; $display("FAIL zero_handoff got out_valid=%b in_ready=%b exp 0 1", bus.out_valid, bus.in_ready); end
    endtask

    // out_ready held high throughout: it must not shortcut RUN
    task automatic test_all_ones();
        int n;
        bus.out_ready = 1'b1;
        accept_word(64'hFFFF_FFFF_FFFF_FFFF);
        wait_valid(n);
        checks++; if (n !== 8) begin failures++; $display("FAIL ones_latency got=%0d exp=8", n); end
        checks++; if (bus.out_c6 !== 48'h6DB6DB6DB6DB) begin failures++; $display("FAIL ones_out_c6 got=%h exp=6db6db6db6db", bus.out_c6); end
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin failures++; $display("FAIL ones_handoff got out_valid=%b in_ready=%b exp 0 1", bus.out_valid, bus.in_ready); end
        checks++; if (bus.out_c6 !== 48'h6DB6DB6DB6DB) begin failures++; $display("FAIL ones_retain got=%h exp=6db6db6db6db", bus.out_c6); end
    endtask

    // in_valid stays high; the second word must wait for the first IDLE edge
    task automatic test_back_to_back();
        int n;
        bus.out_ready = 1'b1;
        bus.in_c      = 64'h1;
        bus.in_valid  = 1'b1;
        @(posedge clk); #1;
        bus.in_c = 64'h4000_0000_0000_0000;
        wait_valid(n);
        checks++; if (n !== 8) begin failures++; $display("FAIL b2b_first_latency got=%0d exp=8", n); end
        checks++; if (bus.out_c6 !== 48'h000000000004) begin failures++; $display("FAIL b2b_first_out_c6 got=%h exp=000000000004", bus.out_c6); end
        @(posedge clk); #1;
        checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL b2b_idle got in_ready=%b out_valid=%b exp 1 0", bus.in_ready, bus.out_valid); end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        checks++; if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin failures++; $display("FAIL b2b_second_accept got busy=%b in_ready=%b exp 1 0", bus.busy, bus.in_ready); end
        wait_valid(n);
        checks++; if (n !== 8) begin failures++; $display("FAIL b2b_second_latency got=%0d exp=8", n); end
        checks++; if (bus.out_c6 !== 48'h040000000000) begin failures++; $display("FAIL b2b_second_out_c6 got=%h exp=040000000000", bus.out_c6); end
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL b2b_final_idle got in_ready=%b exp 1", bus.in_ready); end
    endtask

    task automatic test_backpressure();
        int n;
        int bad;
        bus.out_ready = 1'b0;
        accept_word(64'h0123_4567_89AB_CDEF);
        wait_valid(n);
        checks++; if (n !== 8) begin failures++; $display("FAIL bp_latency got=%0d exp=8", n); end
        checks++; if (bus.out_c6 !== 48'h120369D10F59) begin failures++; $display("FAIL bp_out_c6 got=%h exp=120369d10f59", bus.out_c6); end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_c6 !== 48'h120369D10F59) bad++;
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL bp_hold got=%0d_bad_cycles exp=0 (last out_valid=%b in_ready=%b out_c6=%h)", bad, bus.out_valid, bus.in_ready, bus.out_c6); end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin failures++; $display("FAIL bp_release got out_valid=%b in_ready=%b exp 0 1", bus.out_valid, bus.in_ready); end
    endtask

    task automatic test_mid_run_reset();
        int n;
        int bad;
        accept_word(64'hFFFF_FFFF_FFFF_FFFF);
        n = 0;
        while (bus.lane_idx !== 3'd4 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checks++; if (bus.lane_idx !== 3'd4 || bus.busy !== 1'b1) begin failures++; $display("FAIL mrr_reach_lane4 got lane_idx=%0d busy=%b exp 4 1", bus.lane_idx, bus.busy); end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++; if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL mrr_flags got in_ready=%b busy=%b out_valid=%b exp 1 0 0", bus.in_ready, bus.busy, bus.out_valid); end
        checks++; if (bus.out_c6 !== 48'h0 || bus.lane_idx !== 3'd0) begin failures++; $display("FAIL mrr_clear got out_c6=%h lane_idx=%0d exp 0 0", bus.out_c6, bus.lane_idx); end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) bad++;
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL mrr_no_partial got=%0d_bad_cycles exp=0", bad); end
        accept_word(64'h1);
        wait_valid(n);
        checks++; if (n !== 8) begin failures++; $display("FAIL mrr_fresh_latency got=%0d exp=8", n); end
        checks++; if (bus.out_c6 !== 48'h000000000004) begin failures++; $display("FAIL mrr_fresh_out_c6 got=%h exp=000000000004", bus.out_c6); end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_zero_word();
        test_all_ones();
        test_back_to_back();
        test_backpressure();
        test_mid_run_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
